// File: rtl/div_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package   : div_sched_pkg
// Purpose   : Shared types and constants for the divide-ratio scheduler.
//             FSM state encoding, default ratio width / reset ratio, and the
//             smallest ratio the divider can legally run.
// Revision  : 1.0  initial release
// ============================================================================
package div_sched_pkg;

  localparam int W_DEFAULT         = 8;
  localparam int DEF_RATIO_DEFAULT = 7;
  localparam int MIN_RATIO         = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/div_core.sv
`default_nettype none
// ============================================================================
// Module    : div_core
// Purpose   : Programmable divider counter with near-50% duty decode and an
//             end-of-period tick. The active ratio is held here and replaced
//             only when load is asserted (on a period boundary).
// Ports     : clk_in, rst       clock, async active-high reset
//             load, load_ratio  replace active ratio, restart period at cnt 0
//             ratio             ratio currently driving the counter
//             cnt_last          counter is in the final cycle of the period
//             div_out           divided square wave (registered)
//             div_tick          high in the final cycle of a period (registered)
// Revision  : 1.0  initial release
// ============================================================================
module div_core #(
  parameter int W         = 8,
  parameter int DEF_RATIO = 7
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_ratio,
  output logic [W-1:0] ratio,
  output logic         cnt_last,
  output logic         div_out,
  output logic         div_tick
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] ratio_nxt;
  logic [W:0]   half_nxt;

  assign cnt_last = (cnt == (ratio - W'(1)));

  // Both registered outputs are decoded from the values the counter and
  // ratio will hold after this edge, so they line up with cnt without a
  // combinational path to the pins.
  always_comb begin
    ratio_nxt = load ? load_ratio : ratio;
    cnt_nxt   = (cnt_last || load) ? '0 : (cnt + W'(1));
    // ceil(N/2), computed one bit wider so N = 2^W-1 cannot overflow
    half_nxt  = ({1'b0, ratio_nxt} + (W+1)'(1)) >> 1;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt      <= W'(DEF_RATIO - 1);
      ratio    <= W'(DEF_RATIO);
      div_out  <= 1'b0;
      div_tick <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      ratio    <= ratio_nxt;
      div_out  <= ({1'b0, cnt_nxt} < half_nxt);
      div_tick <= (cnt_nxt == (ratio_nxt - W'(1)));
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_ratio_sched.sv
`default_nettype none
// ============================================================================
// Module    : div_ratio_sched
// Purpose   : Two-requester round-robin scheduler for the divide ratio of a
//             shared clock divider. A granted ratio is applied only at the end
//             of the current output period so div_out never emits a runt.
// Ports     : clk_in, rst        clock, async active-high reset
//             req[1:0]           ratio-change requests, held until ack
//             ratio0, ratio1     requested ratios
//             ack[1:0]           one-cycle completion pulse per requester
//             err                one-cycle pulse with ack for ratio < 2
//             busy               scheduler not idle
//             cur_ratio          ratio currently driving the divider
//             div_out, div_tick  divided clock and end-of-period enable
// Revision  : 1.0  initial release
// ============================================================================
module div_ratio_sched
  import div_sched_pkg::*;
#(
  parameter int W         = W_DEFAULT,
  parameter int DEF_RATIO = DEF_RATIO_DEFAULT
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] ratio0,
  input  logic [W-1:0] ratio1,
  output logic [1:0]   ack,
  output logic         err,
  output logic         busy,
  output logic [W-1:0] cur_ratio,
  output logic         div_out,
  output logic         div_tick
);

  state_t       state;
  state_t       state_nxt;
  logic         rr_last;     // requester granted most recently
  logic         grant;
  logic         rejected;
  logic [W-1:0] nxt_ratio;
  logic         sel;
  logic [W-1:0] sel_ratio;
  logic         sel_ok;
  logic         load;
  logic         cnt_last;

  // --------------------------------------------------------------------------
  // Arbiter: a tie goes to the requester that was not granted last.
  // --------------------------------------------------------------------------
  always_comb begin
    case (req)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      default: sel = ~rr_last;
    endcase
    sel_ratio = sel ? ratio1 : ratio0;
    sel_ok    = (sel_ratio >= W'(MIN_RATIO));
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_nxt = sel_ok ? ST_PEND : ST_ACK;
        end
      end
      ST_PEND: begin
        if (cnt_last) begin
          state_nxt = ST_ACK;
        end
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    ack  = 2'b00;
    err  = 1'b0;
    busy = (state != ST_IDLE);
    load = (state == ST_PEND) && cnt_last;
    if (state == ST_ACK) begin
      ack[grant] = 1'b1;
      err        = rejected;
    end
  end

  // --------------------------------------------------------------------------
  // Grant capture. A rejected request also counts as a grant so that a
  // requester repeatedly asking for an illegal ratio cannot starve the other.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rr_last   <= 1'b1;
      grant     <= 1'b0;
      rejected  <= 1'b0;
      nxt_ratio <= W'(DEF_RATIO);
    end else if ((state == ST_IDLE) && (|req)) begin
      rr_last  <= sel;
      grant    <= sel;
      rejected <= ~sel_ok;
      if (sel_ok) begin
        nxt_ratio <= sel_ratio;
      end
    end
  end

  div_core #(
    .W         (W),
    .DEF_RATIO (DEF_RATIO)
  ) u_core (
    .clk_in     (clk_in),
    .rst        (rst),
    .load       (load),
    .load_ratio (nxt_ratio),
    .ratio      (cur_ratio),
    .cnt_last   (cnt_last),
    .div_out    (div_out),
    .div_tick   (div_tick)
  );

endmodule
`default_nettype wire

// File: doc/div_ratio_sched.md
# div_ratio_sched

Divide-ratio scheduler for the shared 50%-class clock divider: two requesters ask for a new divide ratio, the block arbitrates round-robin, and it applies the winning ratio only at an output-period boundary so `div_out` never produces a runt pulse. The block contains the divider counter itself and runs entirely in the `clk_in` domain. Downstream logic uses `div_out` as a square wave or `div_tick` as a once-per-period enable.

## Interface
- `W`, 8: ratio width; legal ratios are 2 .. 2^W-1.
- `DEF_RATIO`, 7: ratio loaded at reset; must be ≥2.

- `clk_in`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  2  per-requester ratio-change request; held until the matching `ack`.
- `ratio0`  in  W  ratio from requester 0; stable while `req[0]` is high.
- `ratio1`  in  W  ratio from requester 1; stable while `req[1]` is high.
- `ack`  out  2  one-cycle completion pulse per requester.
- `err`  out  1  one-cycle pulse, coincident with `ack`, for a rejected ratio.
- `busy`  out  1  FSM not in IDLE.
- `cur_ratio`  out  W  ratio currently driving the divider.
- `div_out`  out  1  divided square wave, flop-driven.
- `div_tick`  out  1  high during the last `clk_in` cycle of each output period.

## Operation
- Divider core
  - `cnt` counts 0..N-1 and wraps, where N = `cur_ratio`.
  - `div_out` = 1 when `cnt` < H, with H = ceil(N/2). Odd N gives (N+1)/2 high cycles and (N-1)/2 low cycles; even N gives exactly 50% duty.
  - `div_out` and `div_tick` are registered from next-state `cnt`. They are never combinational decodes.
- FSM states: IDLE, PEND, ACK.
  - IDLE → PEND when any `req` is high and the selected ratio is ≥2. The grant is round-robin: the requester not granted last time wins a tie. At that edge, latch the grant index and the ratio into `nxt_ratio`.
  - IDLE → ACK with `err` when the selected ratio is 0 or 1. `cur_ratio` is unchanged.
  - PEND → ACK on the edge that ends a period (`cnt` == N-1). At that edge: `cur_ratio` <= `nxt_ratio`, `cnt` <= 0, `div_out` <= 1.
  - ACK → IDLE unconditionally. During ACK, `ack[grant]` = 1 for one cycle, and `err` = 1 if the request was rejected.
- A request for the current ratio still goes through PEND. There is no shortcut.
- `req` is ignored outside IDLE. A `req` still high in the cycle after its `ack` is treated as a new request, so requesters must drop `req` on seeing `ack`.
- The round-robin pointer updates only on a grant. After reset it favours requester 0.

## Timing
- Reset values: state IDLE, `cur_ratio` = DEF_RATIO, `cnt` = DEF_RATIO-1, `div_out` = 0, `div_tick` = 0, `ack` = 0, `err` = 0, `busy` = 0, RR pointer = 1 (so requester 0 wins first).
- First edge after reset release: `cnt` goes to 0 and `div_out` goes to 1.
- Latency from `req` sampled in IDLE to `ack`:
  - Valid ratio: 2 to N+1 cycles, where N is the old ratio.
  - Rejected ratio: exactly 1 cycle.
- The new ratio takes effect in the cycle after the old period's final cycle. The old period always completes in full.
- `div_tick` is high in the final cycle of the period in which the switch occurs. It reflects the old N.
- Reset asserted mid-PEND: the pending request is dropped with no `ack`, and `cur_ratio` returns to DEF_RATIO.
- `busy` is high in PEND and ACK.

## Structure
- Package `div_sched_pkg`:
  - state enum (IDLE, PEND, ACK);
  - default `W` and `DEF_RATIO`;
  - minimum legal ratio constant `MIN_RATIO` = 2.
- Sub-module `div_core`: counter, duty decode and tick. Inputs: `load`, `load_ratio`. Outputs: `cnt_last`, `div_out`, `div_tick`.
- The top level holds the arbiter and FSM.

## Test plan
- Reset release with DEF_RATIO = 7: `div_out` is 1 for 4 cycles then 0 for 3, repeating. `div_tick` is high on every 7th cycle. `cur_ratio` = 7.
- `req[0]` with ratio 4, raised mid-period: `ack[0]` arrives only after the current 7-cycle period completes. Afterwards the output runs 2 high / 2 low and `cur_ratio` = 4.
- `req[0]` and `req[1]` raised in the same cycle, ratios 3 and 5: requester 0 is acknowledged first. Requester 1 is then served; with the current ratio 3, its `ack[1]` comes 2 to 4 cycles after requester 0's ACK cycle. Final `cur_ratio` = 5, giving 3 high / 2 low.
- `req[1]` with ratio 1: `ack[1]` and `err` both pulse in the cycle after the request is sampled. `cur_ratio` is unchanged and the `div_out` period is undisturbed.
- `rst` pulsed while in PEND: no `ack` is issued. After release, the output restarts at ratio 7 (4 high / 3 low).
- Ratio 255 followed by ratio 2 (wrap and width bounds): the output gives 128 high / 127 low, then 1 high / 1 low.
